// File: rtl/siso_layer_scheduler_pkg.sv
// Shared definitions for the SISO layer scheduler and its row-unit bench.
// The FSM encoding is kept as plain constants so legacy netlists can match it.
package siso_layer_scheduler_pkg;

  // Issue-to-write-back latency of the row unit. It is counted from the
  // scheduler's issue decision: the scheduler's output register doubles as the
  // row unit's input register.
  localparam int RCU_LAT = 14;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/siso_layer_scheduler_if.sv
// Read/write-back link between the layer scheduler (master) and the SISO row unit.
interface siso_layer_scheduler_if #(
  parameter int ADDRWIDTH = 5
);
  logic                 rdlayer;
  logic [ADDRWIDTH-1:0] rdaddress;
  logic                 rden_LLR;
  logic                 rden_E;
  logic                 wren_d;
  logic [ADDRWIDTH-1:0] wraddress_d;

  modport master (
    output rdlayer, rdaddress, rden_LLR, rden_E,
    input  wren_d, wraddress_d
  );

  modport slave (
    input  rdlayer, rdaddress, rden_LLR, rden_E,
    output wren_d, wraddress_d
  );
endinterface

// File: rtl/siso_wb_scoreboard.sv
// Per-address record of LLR write-backs still in flight in the row unit, with
// the read hazard query, the drained flag and bad-write-back detection.
module siso_wb_scoreboard #(
  parameter int ADDRWIDTH = 5,
  parameter int ADDRDEPTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_all,
  input  logic                 set_en,
  input  logic [ADDRWIDTH-1:0] set_addr,
  input  logic                 wb_en,
  input  logic [ADDRWIDTH-1:0] wb_addr,
  input  logic [ADDRWIDTH-1:0] query_addr,
  output logic                 hazard,
  output logic                 empty_next,
  output logic                 wb_err
);

  logic [ADDRDEPTH-1:0] pending_q, pending_d;
  logic [ADDRDEPTH-1:0] set_mask, clr_mask;
  logic                 query_pending, wb_pending;

  // NOTE: every variable assigned in an always_comb gets a default at the top,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    set_mask      = '0;
    clr_mask      = '0;
    query_pending = 1'b0;
    wb_pending    = 1'b0;
    // Compare against each legal address so an out-of-range write-back simply
    // matches nothing and reads as "not pending".
    for (int i = 0; i < ADDRDEPTH; i++) begin
      if (set_en && set_addr == ADDRWIDTH'(i)) set_mask[i] = 1'b1;
      if (wb_en && wb_addr == ADDRWIDTH'(i)) begin
        clr_mask[i] = 1'b1;
        wb_pending  = pending_q[i];
      end
      if (query_addr == ADDRWIDTH'(i)) query_pending = pending_q[i];
    end
    pending_d = clr_all ? '0 : ((pending_q & ~clr_mask) | set_mask);
  end

  // The LLR memory is read-first, so a write landing this cycle still hazards.
  assign hazard     = query_pending | (wb_en && wb_addr == query_addr);
  assign empty_next = ~|(pending_q & ~clr_mask);
  assign wb_err     = wb_en && !wb_pending;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

endmodule

// File: rtl/siso_layer_scheduler.sv
// Read-side controller for the pipelined SISO row unit: walks iterations,
// layers and row-block addresses, stalling reads that would fetch a stale LLR.
module siso_layer_scheduler
  import siso_layer_scheduler_pkg::*;
#(
  parameter int LAYERS    = 2,
  parameter int ADDRWIDTH = 5,
  parameter int ADDRDEPTH = 20,
  parameter int ITERW     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ITERW-1:0]       max_iter,
  input  logic                   early_stop,
  siso_layer_scheduler_if.master rcu,
  output logic                   busy,
  output logic                   done,
  output logic [ITERW-1:0]       iter_count,
  output logic                   protocol_err
);

  localparam int LW = (LAYERS > 1) ? $clog2(LAYERS) : 1;

  logic [1:0]           state_q, state_d;
  logic [ADDRWIDTH-1:0] a_q, a_d;
  logic [LW-1:0]        l_q, l_d;
  logic [ITERW-1:0]     iter_q, iter_d;
  logic [ITERW-1:0]     max_q, max_d;
  logic                 rden_llr_q, rden_llr_d;
  logic                 rden_e_q, rden_e_d;
  logic                 rdlayer_q, rdlayer_d;
  logic [ADDRWIDTH-1:0] rdaddr_q, rdaddr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 accept, issue, hazard, empty_next, wb_err;
  logic                 last_a, last_l;
  logic [ITERW-1:0]     iter_inc, eff_max;

  assign accept   = (state_q == S_IDLE) && start;
  assign issue    = (state_q == S_ISSUE) && !hazard;
  assign last_a   = (a_q == ADDRWIDTH'(ADDRDEPTH - 1));
  assign last_l   = (l_q == LW'(LAYERS - 1));
  assign iter_inc = iter_q + 1'b1;
  assign eff_max  = (max_q == '0) ? ITERW'(1) : max_q;

  siso_wb_scoreboard #(
    .ADDRWIDTH (ADDRWIDTH),
    .ADDRDEPTH (ADDRDEPTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .clr_all    (accept),
    .set_en     (issue),
    .set_addr   (a_q),
    .wb_en      (rcu.wren_d),
    .wb_addr    (rcu.wraddress_d),
    .query_addr (a_q),
    .hazard     (hazard),
    .empty_next (empty_next),
    .wb_err     (wb_err)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    l_d        = l_q;
    iter_d     = iter_q;
    max_d      = max_q;
    rden_llr_d = 1'b0;
    rden_e_d   = 1'b0;
    rdlayer_d  = rdlayer_q;
    rdaddr_d   = rdaddr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = accept ? 1'b0 : (err_q | wb_err);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          a_d     = '0;
          l_d     = '0;
          iter_d  = '0;
          max_d   = max_iter;
          busy_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          rden_llr_d = 1'b1;
          // E memory holds nothing useful until one full iteration has run.
          rden_e_d   = (iter_q != '0);
          rdlayer_d  = l_q[0];
          rdaddr_d   = a_q;
          if (!last_a) begin
            a_d = a_q + 1'b1;
          end else begin
            a_d = '0;
            if (!last_l) begin
              l_d = l_q + 1'b1;
            end else begin
              l_d    = '0;
              iter_d = iter_inc;
              if (iter_inc == eff_max || early_stop) state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (empty_next) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      l_q        <= '0;
      iter_q     <= '0;
      max_q      <= '0;
      rden_llr_q <= 1'b0;
      rden_e_q   <= 1'b0;
      rdlayer_q  <= 1'b0;
      rdaddr_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      l_q        <= l_d;
      iter_q     <= iter_d;
      max_q      <= max_d;
      rden_llr_q <= rden_llr_d;
      rden_e_q   <= rden_e_d;
      rdlayer_q  <= rdlayer_d;
      rdaddr_q   <= rdaddr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rcu.rden_LLR  = rden_llr_q;
  assign rcu.rden_E    = rden_e_q;
  assign rcu.rdlayer   = rdlayer_q;
  assign rcu.rdaddress = rdaddr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign iter_count    = iter_q;
  assign protocol_err  = err_q;

endmodule

// File: tb/tb_siso_layer_scheduler.sv
// Bench for siso_layer_scheduler: a loopback row-unit model feeds write-backs,
// and an issue-timing model derived from the stall rules predicts every read.
module tb_siso_layer_scheduler;
  import siso_layer_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst, start_a, start_b, early_stop;
  logic [4:0] max_iter;
  int cyc = 0;
  int checks = 0, passes = 0, fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  siso_layer_scheduler_if #(.ADDRWIDTH(5)) ifa ();
  siso_layer_scheduler_if #(.ADDRWIDTH(5)) ifb ();

  logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [4:0] iter_a, iter_b;

  siso_layer_scheduler #(.LAYERS(2), .ADDRWIDTH(5), .ADDRDEPTH(20), .ITERW(5)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .max_iter(max_iter), .early_stop(early_stop),
    .rcu(ifa), .busy(busy_a), .done(done_a), .iter_count(iter_a), .protocol_err(err_a));

  siso_layer_scheduler #(.LAYERS(2), .ADDRWIDTH(5), .ADDRDEPTH(4), .ITERW(5)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .max_iter(max_iter), .early_stop(early_stop),
    .rcu(ifb), .busy(busy_b), .done(done_b), .iter_count(iter_b), .protocol_err(err_b));

  // Only the selected instance sees the loopback; the other idles.
  logic       sel, swap_mode, inj_en, wb_en;
  logic [4:0] inj_addr, wb_addr;
  assign ifa.wren_d      = wb_en && !sel;
  assign ifa.wraddress_d = wb_addr;
  assign ifb.wren_d      = wb_en && sel;
  assign ifb.wraddress_d = wb_addr;

  logic       o_rden, o_e, o_layer, o_busy, o_done, o_err;
  logic [4:0] o_addr, o_iter;
  assign o_rden  = sel ? ifb.rden_LLR  : ifa.rden_LLR;
  assign o_e     = sel ? ifb.rden_E    : ifa.rden_E;
  assign o_layer = sel ? ifb.rdlayer   : ifa.rdlayer;
  assign o_addr  = sel ? ifb.rdaddress : ifa.rdaddress;
  assign o_busy  = sel ? busy_b : busy_a;
  assign o_done  = sel ? done_b : done_a;
  assign o_err   = sel ? err_b  : err_a;
  assign o_iter  = sel ? iter_b : iter_a;

  bit          es_hist [8192];
  bit          sched_v [1024];
  logic [4:0]  sched_a [1024];
  bit          bench_pend [32];
  logic [63:0] obs_q[$], exp_q[$];
  int          done_cyc = -1, slot7 = 0;
  int          exp_done, exp_iter;

  function automatic logic [63:0] pack(input int t, input int l, input int a, input bit e);
    return {32'(t), 8'(l), 8'(a), 8'(e), 8'd0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Row-unit loopback: a read seen on the outputs at cycle c writes back at
  // c + RCU_LAT - 1 (the scheduler's output register is the first stage).
  always @(negedge clk) begin
    int slot;
    es_hist[cyc % 8192] = early_stop;
    if (o_rden) begin
      check($sformatf("fresh_read_a%0d", o_addr), 64'(bench_pend[o_addr]), 64'd0);
      bench_pend[o_addr] = 1'b1;
      obs_q.push_back(pack(cyc, int'(o_layer), int'(o_addr), o_e));
      slot = (cyc + RCU_LAT - 1) % 1024;
      sched_v[slot] = 1'b1;
      sched_a[slot] = o_addr;
      // Swap mode returns address 7 late, in the slot address 13 would use.
      if (swap_mode && !o_layer && !o_e && o_addr == 5'd7) slot7 = slot;
      if (swap_mode && !o_layer && !o_e && o_addr == 5'd13) begin
        sched_a[slot]  = 5'd7;
        sched_a[slot7] = 5'd13;
      end
    end
    slot = cyc % 1024;
    if (sched_v[slot]) begin
      wb_en   = 1'b1;
      wb_addr = sched_a[slot];
      bench_pend[sched_a[slot]] = 1'b0;
      sched_v[slot] = 1'b0;
    end else begin
      wb_en   = inj_en;
      wb_addr = inj_addr;
    end
    if (o_done) done_cyc = cyc;
  end

  // Expected read timing: reads go out back-to-back, except that a read of an
  // address may only reach the LLR memory two cycles after its write-back.
  task automatic run_model(input int depth, input int mi, input int s, input bit swap);
    int ready[32];
    int t, wb, it, eff, t7;
    bit stop;
    exp_q.delete();
    foreach (ready[i]) ready[i] = 0;
    t = s + 1; it = 0; stop = 0; exp_done = 0; t7 = 0;
    eff = (mi == 0) ? 1 : mi;
    while (!stop) begin
      for (int l = 0; l < 2; l++) begin
        for (int a = 0; a < depth; a++) begin
          t = (t + 1 > ready[a]) ? t + 1 : ready[a];
          exp_q.push_back(pack(t, l, a, it > 0));
          wb = t + RCU_LAT - 1;
          if (swap && it == 0 && l == 0 && a == 7) t7 = t;
          if (swap && it == 0 && l == 0 && a == 13) begin
            ready[7] = wb + 2;
            wb = t7 + RCU_LAT - 1;
          end
          ready[a] = wb + 2;
          if (wb > exp_done) exp_done = wb;
        end
      end
      it++;
      // early_stop counts only in the cycle the final read is decided.
      if (it == eff || es_hist[(t - 1) % 8192]) stop = 1;
    end
    exp_done = exp_done + 1;
    exp_iter = it;
  endtask

  task automatic do_run(input bit s_sel, input int mi, input bit swap, input int es_mode);
    int s, n;
    sel = s_sel; swap_mode = swap;
    max_iter = 5'(mi);
    early_stop = (es_mode == 1);
    tick;
    obs_q.delete(); done_cyc = -1;
    if (s_sel) start_b = 1'b1; else start_a = 1'b1;
    s = cyc;
    tick;
    start_a = 1'b0; start_b = 1'b0;
    check("busy_after_start", 64'(o_busy), 64'd1);
    check("err_after_start", 64'(o_err), 64'd0);
    n = 0;
    while (done_cyc < 0 && n < 3000) begin
      if (es_mode == 2) early_stop = ($urandom_range(0, 15) == 0);
      tick;
      n++;
    end
    early_stop = 1'b0;
    check("done_seen", 64'(done_cyc >= 0), 64'd1);
    run_model(s_sel ? 4 : 20, mi, s, swap);
    check("issue_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("issue%0d", i), obs_q[i], exp_q[i]);
    check("done_cycle", 64'(done_cyc), 64'(exp_done));
    check("iter_count", 64'(o_iter), 64'(exp_iter));
    check("busy_after_done", 64'(o_busy), 64'd0);
    check("err_after_run", 64'(o_err), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; max_iter = '0; early_stop = 1'b0;
    sel = 1'b0; swap_mode = 1'b0; inj_en = 1'b0; inj_addr = '0;
    repeat (3) tick;
    check("rst_rden_a", 64'({ifa.rden_LLR, ifa.rden_E, ifa.rdlayer}), 64'd0);
    check("rst_addr_a", 64'(ifa.rdaddress), 64'd0);
    check("rst_ctrl_a", 64'({busy_a, done_a, err_a}), 64'd0);
    check("rst_iter_a", 64'(iter_a), 64'd0);
    check("rst_all_b", 64'({ifb.rden_LLR, ifb.rden_E, ifb.rdlayer, ifb.rdaddress,
                            busy_b, done_b, err_b, iter_b}), 64'd0);
    rst = 1'b0;
    tick;

    // Three full iterations, deep memory: never stalls.
    do_run(0, 3, 0, 0);
    check("d20_issues", 64'(obs_q.size()), 64'd120);
    if (obs_q.size() == 120)
      check("d20_stall_free", 64'(obs_q[119][63:32] - obs_q[0][63:32]), 64'd119);
    check("d20_iter", 64'(iter_a), 64'd3);

    // Write-back of address 7 collides with its next read: deferred one cycle.
    do_run(0, 1, 1, 0);
    if (obs_q.size() == 40)
      check("defer7_gap", 64'(obs_q[27][63:32] - obs_q[26][63:32]), 64'd2);

    // early_stop held high: honoured only at the end of the first iteration.
    do_run(0, 10, 0, 1);
    check("es_issues", 64'(obs_q.size()), 64'd40);
    check("es_iter", 64'(iter_a), 64'd1);

    // Random iteration counts (0 means 1) and sporadic early_stop pulses.
    repeat (3) do_run(0, $urandom_range(0, 3), 0, 2);

    // Shallow memory: each layer boundary waits 11 cycles for write-backs.
    do_run(1, 2, 0, 0);
    check("d4_issues", 64'(obs_q.size()), 64'd16);
    if (obs_q.size() == 16)
      for (int i = 4; i < 16; i += 4)
        check($sformatf("d4_boundary%0d", i), 64'(obs_q[i][63:32] - obs_q[i-1][63:32]), 64'd12);

    // Spurious write-back to an idle address sets the sticky error.
    sel = 1'b0;
    inj_addr = 5'd3; inj_en = 1'b1;
    tick;
    inj_en = 1'b0;
    check("spurious_err", 64'(err_a), 64'd1);
    repeat (4) tick;
    check("spurious_sticky", 64'(err_a), 64'd1);
    do_run(0, 1, 0, 0);
    inj_addr = 5'd25; inj_en = 1'b1;
    tick;
    inj_en = 1'b0;
    check("range_err", 64'(err_a), 64'd1);

    // Reset in the middle of issuing, then a clean restart.
    max_iter = 5'd3;
    tick;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    repeat (30) tick;
    rst = 1'b1;
    tick;
    check("midrst_rd", 64'({ifa.rden_LLR, ifa.rden_E, ifa.rdlayer, ifa.rdaddress}), 64'd0);
    check("midrst_ctrl", 64'({busy_a, done_a, err_a, iter_a}), 64'd0);
    check("midrst_state", 64'(dut_a.state_q), 64'(S_IDLE));
    rst = 1'b0;
    foreach (sched_v[i]) sched_v[i] = 1'b0;
    foreach (bench_pend[i]) bench_pend[i] = 1'b0;
    repeat (3) tick;
    do_run(0, 1, 0, 0);
    if (obs_q.size() == 40)
      check("restart_stall_free", 64'(obs_q[39][63:32] - obs_q[0][63:32]), 64'd39);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
